tile_layer_mixer: RTL

- Parametrised successor to the two-layer M72 tile-board front end.
- Holds per-layer V/H scroll registers written over the CPU I/O bus. CPU writes go to a shadow copy; the active copy loads at line start, so mid-line writes never tear.
- Per-pixel priority mixer for NUM_LAYERS layer pixel streams: transparency, per-pixel priority override, layer enable/blank.
- Sits between the per-layer tile fetchers and the palette lookup; outputs one palette index per pixel.

---
 rtl/tile_layer_mixer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/tile_layer_mixer.sv
// Multi-layer tile front end: shadowed per-layer V/H scroll registers written over CPU I/O, latched at line start, plus a 2-stage per-pixel priority mixer.
// Optional build macro MIXER_SOLO_EN adds a CTRL-selected solo layer; undefined, CTRL[15:12] are not stored.
module tile_layer_mixer #(
    parameter int          NUM_LAYERS = 2,
    parameter int          PIX_W      = 4,
    parameter int          PAL_W      = 4,
    parameter int          SCROLL_W   = 10,
    parameter logic [1:0]  IO_BASE    = 2'b10,
    localparam int         LW         = $clog2(NUM_LAYERS + 1)
) (
    input  logic                           sys_clk,
    input  logic                           reset_n,
    input  logic                           DCLK,
    input  logic                           IOWR,
    input  logic [7:1]                     A,
    input  logic [15:0]                    DIN,
    input  logic [1:0]                     BYTE_SEL,
    input  logic                           NL,
    input  logic [NUM_LAYERS*PIX_W-1:0]    LPIX,
    input  logic [NUM_LAYERS*PAL_W-1:0]    LPAL,
    input  logic [NUM_LAYERS-1:0]          LPRI,
    output logic [NUM_LAYERS*SCROLL_W-1:0] VSCROLL,
    output logic [NUM_LAYERS*SCROLL_W-1:0] HSCROLL,
    output logic [PIX_W-1:0]               PIX_OUT,
    output logic [PAL_W-1:0]               PAL_OUT,
    output logic [LW-1:0]                  LAYER_OUT,
    output logic                           OPAQUE
);

    logic [SCROLL_W-1:0] shd_v     [NUM_LAYERS];
    logic [SCROLL_W-1:0] shd_h     [NUM_LAYERS];
    logic [SCROLL_W-1:0] act_v     [NUM_LAYERS];
    logic [SCROLL_W-1:0] act_h     [NUM_LAYERS];
    logic [SCROLL_W-1:0] shd_v_nxt [NUM_LAYERS];
    logic [SCROLL_W-1:0] shd_h_nxt [NUM_LAYERS];

    logic [NUM_LAYERS-1:0] ctrl_en;
    logic                  ctrl_blank;
`ifdef MIXER_SOLO_EN
    logic [2:0]            ctrl_solo_sel;
    logic                  ctrl_solo_en;
`endif

    logic       nl_q;
    logic       nl_rise;
    logic       wr_hit;
    logic       ctrl_wr;
    logic [4:0] idx;

    // DIN bits above SCROLL_W (and unused CTRL bits) are intentionally dropped
    logic unused_din;
    assign unused_din = ^DIN;

    assign nl_rise = NL && !nl_q;
    assign idx     = A[5:1];
    assign wr_hit  = IOWR && (A[7:6] == IO_BASE);
    assign ctrl_wr = wr_hit && (idx == 5'h1F);

    function automatic logic [SCROLL_W-1:0] merge_bytes(
        input logic [SCROLL_W-1:0] old_val,
        input logic [15:0]         data,
        input logic [1:0]          lanes
    );
        logic [SCROLL_W-1:0] r;
        r = old_val;
        for (int i = 0; i < SCROLL_W; i++) begin
            if ((i < 8) ? lanes[0] : lanes[1])
                r[i] = data[i];
        end
        return r;
    endfunction

    always_comb begin
        for (int k = 0; k < NUM_LAYERS; k++) begin
            shd_v_nxt[k] = shd_v[k];
            shd_h_nxt[k] = shd_h[k];
            if (wr_hit && ({1'b0, idx} == 6'(2 * k)))
                shd_v_nxt[k] = merge_bytes(shd_v[k], DIN, BYTE_SEL);
            if (wr_hit && ({1'b0, idx} == 6'(2 * k + 1)))
                shd_h_nxt[k] = merge_bytes(shd_h[k], DIN, BYTE_SEL);
        end
    end

    // Line latch copies the post-write shadow value so a same-cycle write bypasses into active
    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            nl_q       <= 1'b0;
            ctrl_en    <= '1;
            ctrl_blank <= 1'b0;
`ifdef MIXER_SOLO_EN
            ctrl_solo_sel <= 3'd0;
            ctrl_solo_en  <= 1'b0;
`endif
            for (int k = 0; k < NUM_LAYERS; k++) begin
                shd_v[k] <= '0;
                shd_h[k] <= '0;
                act_v[k] <= '0;
                act_h[k] <= '0;
            end
        end else begin
            nl_q <= NL;
            for (int k = 0; k < NUM_LAYERS; k++) begin
                shd_v[k] <= shd_v_nxt[k];
                shd_h[k] <= shd_h_nxt[k];
                if (nl_rise) begin
                    act_v[k] <= shd_v_nxt[k];
                    act_h[k] <= shd_h_nxt[k];
                end
            end
            if (ctrl_wr) begin
                if (BYTE_SEL[0])
                    ctrl_en <= DIN[NUM_LAYERS-1:0];
                if (BYTE_SEL[1]) begin
                    ctrl_blank <= DIN[8];
`ifdef MIXER_SOLO_EN
                    ctrl_solo_sel <= DIN[14:12];
                    ctrl_solo_en  <= DIN[15];
`endif
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_scroll_out
        assign VSCROLL[g*SCROLL_W +: SCROLL_W] = act_v[g];
        assign HSCROLL[g*SCROLL_W +: SCROLL_W] = act_h[g];
    end

    logic [NUM_LAYERS*PIX_W-1:0] s1_pix;
    logic [NUM_LAYERS*PAL_W-1:0] s1_pal;
    logic [NUM_LAYERS-1:0]       s1_pri;

    logic              any_found;
    logic              pri_found;
    logic [LW-1:0]     any_idx;
    logic [LW-1:0]     pri_idx;
    logic [LW-1:0]     win_idx;
    logic              cand;
    logic [PIX_W-1:0]  pix_k;
    logic [PIX_W-1:0]  nxt_pix;
    logic [PAL_W-1:0]  nxt_pal;
    logic [LW-1:0]     nxt_layer;
    logic              nxt_opaque;

    always_comb begin
        any_found  = 1'b0;
        pri_found  = 1'b0;
        any_idx    = '0;
        pri_idx    = '0;
        cand       = 1'b0;
        pix_k      = '0;
        nxt_pix    = '0;
        nxt_pal    = '0;
        nxt_layer  = LW'(NUM_LAYERS);
        nxt_opaque = 1'b0;
        // Ascending scan: the last hit is the highest-numbered candidate
        for (int k = 0; k < NUM_LAYERS; k++) begin
            pix_k = s1_pix[k*PIX_W +: PIX_W];
            cand  = ctrl_en[k] && (pix_k != '0);
`ifdef MIXER_SOLO_EN
            if (ctrl_solo_en && (ctrl_solo_sel != 3'(k)))
                cand = 1'b0;
`endif
            if (cand) begin
                any_found = 1'b1;
                any_idx   = LW'(k);
                if (s1_pri[k]) begin
                    pri_found = 1'b1;
                    pri_idx   = LW'(k);
                end
            end
        end
        win_idx = pri_found ? pri_idx : any_idx;
        if (any_found && !ctrl_blank) begin
            nxt_layer  = win_idx;
            nxt_opaque = 1'b1;
            for (int k = 0; k < NUM_LAYERS; k++) begin
                if (win_idx == LW'(k)) begin
                    nxt_pix = s1_pix[k*PIX_W +: PIX_W];
                    nxt_pal = s1_pal[k*PAL_W +: PAL_W];
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            s1_pix    <= '0;
            s1_pal    <= '0;
            s1_pri    <= '0;
            PIX_OUT   <= '0;
            PAL_OUT   <= '0;
            LAYER_OUT <= '0;
            OPAQUE    <= 1'b0;
        end else if (DCLK) begin
            s1_pix    <= LPIX;
            s1_pal    <= LPAL;
            s1_pri    <= LPRI;
            PIX_OUT   <= nxt_pix;
            PAL_OUT   <= nxt_pal;
            LAYER_OUT <= nxt_layer;
            OPAQUE    <= nxt_opaque;
        end
    end

endmodule
